// File: rtl/multi_accumulator_pkg.sv
// Shared types for the multi-channel accumulator.
// Contents: STATE_W (state encoding width) and state_e (ST_ACCUM, ST_DRAIN).
package multi_accumulator_pkg;

  localparam int unsigned STATE_W = 1;

  typedef enum logic [STATE_W-1:0] {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/acc_lane.sv
// One accumulator channel: a running sum register plus a sticky overflow flag.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   add_en_i      add data_i into the sum this cycle
//   data_i        unsigned sample, zero-extended before the add
//   clr_i         clear sum and overflow flag (wins over add_en_i)
//   sum_o         current sum
//   ovf_o         sticky overflow flag
// Build option: MULTI_ACCUMULATOR_SAT_EN defined clamps the sum at all-ones on a
// carry out; undefined wraps modulo 2^ACC_WIDTH_P. The flag is the same in both.
module acc_lane
  import multi_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH_P     = 8,
  parameter int unsigned ACC_WIDTH_P = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   add_en_i,
  input  logic [WIDTH_P-1:0]     data_i,
  input  logic                   clr_i,
  output logic [ACC_WIDTH_P-1:0] sum_o,
  output logic                   ovf_o
);

  logic [ACC_WIDTH_P-1:0] sum_q, sum_d;
  logic                   ovf_q, ovf_d;
  logic [ACC_WIDTH_P:0]   sum_ext;
  logic                   carry;

  // One extra bit so the carry out is observable.
  assign sum_ext = {1'b0, sum_q} + {{(ACC_WIDTH_P - WIDTH_P + 1){1'b0}}, data_i};
  assign carry   = sum_ext[ACC_WIDTH_P];

  always_comb begin
    sum_d = sum_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      sum_d = '0;
      ovf_d = 1'b0;
    end else if (add_en_i) begin
      ovf_d = ovf_q | carry;
`ifdef MULTI_ACCUMULATOR_SAT_EN
      sum_d = carry ? '1 : sum_ext[ACC_WIDTH_P-1:0];
`else
      sum_d = sum_ext[ACC_WIDTH_P-1:0];
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  assign sum_o = sum_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/multi_accumulator.sv
// Multi-channel accumulator with a valid/ready sample input and a drain stream
// that reads out and clears every channel in index order.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   in_valid_i/in_ready_o      input handshake; ready only while accumulating
//   in_data_i, in_chan_i       sample and target channel (out-of-range dropped)
//   drain_i                    start a drain (ignored while draining)
//   out_valid_o/out_ready_i    drain beat handshake
//   out_data_o, out_chan_o     sum and channel of the current beat
//   out_last_o                 current beat is the last channel
//   ovf_o                      per-channel sticky overflow
//   busy_o                     draining
// Build option: MULTI_ACCUMULATOR_SAT_EN selects saturating sums (see acc_lane).
module multi_accumulator
  import multi_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH_P     = 8,
  parameter int unsigned ACC_WIDTH_P = 16,
  parameter int unsigned CHANNELS_P  = 4,
  localparam int unsigned CHAN_W     = $clog2(CHANNELS_P)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [WIDTH_P-1:0]     in_data_i,
  input  logic [CHAN_W-1:0]      in_chan_i,
  input  logic                   drain_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [ACC_WIDTH_P-1:0] out_data_o,
  output logic [CHAN_W-1:0]      out_chan_o,
  output logic                   out_last_o,
  output logic [CHANNELS_P-1:0]  ovf_o,
  output logic                   busy_o
);

  state_e              state_q, state_d;
  logic [CHAN_W-1:0]   idx_q, idx_d;
  logic                draining;
  logic                in_hs, out_hs;
  logic                idx_last;
  logic [ACC_WIDTH_P-1:0] sums [CHANNELS_P];

  assign draining = (state_q == ST_DRAIN);
  assign in_hs    = in_valid_i & in_ready_o;
  assign out_hs   = draining & out_ready_i;
  assign idx_last = (idx_q == CHAN_W'(CHANNELS_P - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_ACCUM: begin
        if (drain_i) begin
          state_d = ST_DRAIN;
          idx_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (out_ready_i) begin
          if (idx_last) begin
            state_d = ST_ACCUM;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + CHAN_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_ACCUM;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_ACCUM;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // An out-of-range channel matches no lane, so the beat is accepted and dropped.
  for (genvar gi = 0; gi < CHANNELS_P; gi++) begin : g_lane
    logic add_en, clr;
    assign add_en = in_hs && (in_chan_i == CHAN_W'(gi));
    assign clr    = out_hs && (idx_q == CHAN_W'(gi));

    acc_lane #(
      .WIDTH_P    (WIDTH_P),
      .ACC_WIDTH_P(ACC_WIDTH_P)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .add_en_i(add_en),
      .data_i  (in_data_i),
      .clr_i   (clr),
      .sum_o   (sums[gi]),
      .ovf_o   (ovf_o[gi])
    );
  end

  // All outputs come from registered state only; no input-to-output paths.
  assign in_ready_o  = (state_q == ST_ACCUM);
  assign busy_o      = draining;
  assign out_valid_o = draining;
  assign out_data_o  = draining ? sums[idx_q] : '0;
  assign out_chan_o  = draining ? idx_q : '0;
  assign out_last_o  = draining & idx_last;

endmodule

// File: tb/tb_multi_accumulator.sv
module tb_multi_accumulator;

  localparam int unsigned WIDTH_P     = 8;
  localparam int unsigned ACC_WIDTH_P = 16;
  localparam int unsigned CHANNELS_P  = 4;
  localparam int unsigned CHAN_W      = 2;

`ifdef MULTI_ACCUMULATOR_SAT_EN
  localparam logic [15:0] OVF_SUM = 16'hFFFF;
`else
  localparam logic [15:0] OVF_SUM = 16'h0000;
`endif

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH_P-1:0]     in_data;
  logic [CHAN_W-1:0]      in_chan;
  logic                   drain;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_WIDTH_P-1:0] out_data;
  logic [CHAN_W-1:0]      out_chan;
  logic                   out_last;
  logic [CHANNELS_P-1:0]  ovf;
  logic                   busy;

  int n_cmp = 0;
  int n_err = 0;

  multi_accumulator #(
    .WIDTH_P    (WIDTH_P),
    .ACC_WIDTH_P(ACC_WIDTH_P),
    .CHANNELS_P (CHANNELS_P)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_chan_i  (in_chan),
    .drain_i    (drain),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_chan_o (out_chan),
    .out_last_o (out_last),
    .ovf_o      (ovf),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic beat(input logic [CHAN_W-1:0] ch, input logic [WIDTH_P-1:0] d);
    in_valid = 1'b1;
    in_chan  = ch;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic start_drain();
    drain = 1'b1;
    @(negedge clk);
    drain = 1'b0;
  endtask

  task automatic drain_beats(input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3,
                             input logic [3:0] ovf_mask, input int stall);
    logic [15:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          check_eq("stall_valid", 32'(out_valid), 32'd1);
          check_eq("stall_chan", 32'(out_chan), 32'd0);
          check_eq("stall_data", 32'(out_data), 32'(e[0]));
          @(negedge clk);
        end
      end
      check_eq("beat_valid", 32'(out_valid), 32'd1);
      check_eq("beat_busy", 32'(busy), 32'd1);
      check_eq("beat_in_ready", 32'(in_ready), 32'd0);
      check_eq("beat_chan", 32'(out_chan), 32'(i));
      check_eq("beat_data", 32'(out_data), 32'(e[i]));
      check_eq("beat_last", 32'(out_last), (i == 3) ? 32'd1 : 32'd0);
      check_eq("beat_ovf", 32'(ovf[i]), 32'(ovf_mask[i]));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    check_eq("end_busy", 32'(busy), 32'd0);
    check_eq("end_valid", 32'(out_valid), 32'd0);
    check_eq("end_in_ready", 32'(in_ready), 32'd1);
    check_eq("end_ovf", 32'(ovf), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_chan   = '0;
    drain     = 1'b0;
    out_ready = 1'b0;
    // Beat offered during reset must be discarded.
    in_valid = 1'b1; in_chan = 2'd1; in_data = 8'd99;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;

    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_chan", 32'(out_chan), 32'd0);
    check_eq("rst_last", 32'(out_last), 32'd0);

    // Basic accumulate and drain.
    beat(2'd0, 8'd5);
    beat(2'd0, 8'd7);
    beat(2'd2, 8'd255);
    beat(2'd1, 8'd0);
    start_drain();
    drain_beats(16'd12, 16'd0, 16'd255, 16'd0, 4'b0000, 0);
    start_drain();
    drain_beats(16'd0, 16'd0, 16'd0, 16'd0, 4'b0000, 0);

    // Overflow on ch1: 255 * 257 = 65535, then +1 carries out.
    for (int k = 0; k < 257; k++) beat(2'd1, 8'd255);
    check_eq("no_ovf_yet", 32'(ovf), 32'd0);
    beat(2'd1, 8'd1);
    check_eq("ovf_set", 32'(ovf), 32'b0010);
    start_drain();
    drain_beats(16'd0, OVF_SUM, 16'd0, 16'd0, 4'b0010, 0);

    // Stall on the ch0 beat.
    beat(2'd0, 8'd6);
    start_drain();
    drain_beats(16'd6, 16'd0, 16'd0, 16'd0, 4'b0000, 3);

    // Beat accepted in the same cycle as drain_i is included.
    in_valid = 1'b1; in_chan = 2'd3; in_data = 8'd9; drain = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; drain = 1'b0;
    drain_beats(16'd0, 16'd0, 16'd0, 16'd9, 4'b0000, 0);

    // Input held during a drain waits for ACCUM.
    start_drain();
    in_valid = 1'b1; in_chan = 2'd0; in_data = 8'd4;
    drain_beats(16'd0, 16'd0, 16'd0, 16'd0, 4'b0000, 0);
    @(negedge clk);
    in_valid = 1'b0;
    start_drain();
    drain_beats(16'd4, 16'd0, 16'd0, 16'd0, 4'b0000, 0);

    // Reset mid-drain after the ch1 beat.
    beat(2'd0, 8'd1);
    beat(2'd1, 8'd2);
    beat(2'd2, 8'd3);
    for (int k = 0; k < 257; k++) beat(2'd3, 8'd255);
    beat(2'd3, 8'd1);
    check_eq("ovf3_set", 32'(ovf), 32'b1000);
    start_drain();
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    check_eq("pre_rst_chan", 32'(out_chan), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("mid_rst_ovf", 32'(ovf), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    start_drain();
    drain_beats(16'd0, 16'd0, 16'd0, 16'd0, 4'b0000, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
